// File: rtl/fib_stream_gen.sv
// Fibonacci-recurrence generator presenting element a on a valid/ready stream.
// Supports runtime reseed, wrapping or saturating add, a sticky overflow flag, an index and an optional stop count.
module fib_stream_gen #(
    parameter int unsigned       WIDTH    = 8,
    parameter logic [WIDTH-1:0]  SEED_A   = '0,
    parameter logic [WIDTH-1:0]  SEED_B   = WIDTH'(1),
    parameter int unsigned       SATURATE = 0,
    parameter int unsigned       IDX_W    = 16,
    parameter int unsigned       STOP_AT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_a,
    input  logic [WIDTH-1:0] load_b,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_ovf,
    output logic [IDX_W-1:0] idx,
    output logic             done
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   full;
    logic             carry;
    logic [WIDTH-1:0] sum;
    logic             beat;
    logic             stop_hit;

    always_comb begin
        full     = {1'b0, a_q} + {1'b0, b_q};
        carry    = full[WIDTH];
        sum      = (SATURATE != 0 && carry) ? '1 : full[WIDTH-1:0];
        beat     = (state_q == S_EMIT) && out_ready;
        stop_hit = (STOP_AT != 0) && (idx_q == IDX_W'(STOP_AT));

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;

        // Load overrides any same-cycle advance; the beat is still consumed downstream.
        if (load) begin
            a_d     = load_a;
            b_d     = load_b;
            idx_d   = '0;
            ovf_d   = 1'b0;
            state_d = S_INIT;
        end else begin
            unique case (state_q)
                S_INIT: state_d = S_EMIT;
                S_EMIT: begin
                    if (beat) begin
                        if (en) begin
                            a_d   = b_q;
                            b_d   = sum;
                            idx_d = idx_q + 1'b1;
                            if (carry) ovf_d = 1'b1;
                        end
                        if (stop_hit) state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            a_q     <= SEED_A;
            b_q     <= SEED_B;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_data  = a_q;
    assign out_valid = (state_q == S_EMIT);
    assign done      = (state_q == S_DONE);
    assign idx       = idx_q;
    assign out_ovf   = ovf_q;

endmodule
